// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: sizing of occupancy counters and pointers.
package fifo_pkg;

    // A FIFO of 2^depth entries needs depth+1 bits to represent 0..2^depth.
    function automatic int occ_width(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: independent write port, registered read with read-enable.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [DEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [DEPTH-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<DEPTH)-1];
    logic [WIDTH-1:0] r_rdata;

    // Contents are never cleared; the read register holds its value when i_re=0.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO: sync-read RAM whose read register doubles as the output stage.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int AFULL_LEVEL  = (1 << DEPTH) - 2,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             not_full,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    input  logic             flush,
    output logic [DEPTH:0]   count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow
);

    localparam int CW = occ_width(DEPTH);
    localparam logic [CW-1:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

    logic [CW-1:0] r_wrptr;
    logic [CW-1:0] r_rdptr;
    logic [CW-1:0] r_count;
    logic          r_rvalid;
    logic          r_overflow;

    logic w_ram_empty;
    logic w_full;
    logic w_pop;
    logic w_wr_ok;
    logic w_prefetch;

    // Handshake: a write is taken when wr & not_full; the head is taken when
    // rvalid & rready. flush and reset override both in the same cycle.
    assign w_ram_empty = (r_wrptr == r_rdptr);
    assign w_full      = (r_count == CAPACITY);
    assign w_pop       = r_rvalid & rready;
    assign w_wr_ok     = wr & ~w_full & ~flush & ~reset;
    assign w_prefetch  = ~w_ram_empty & (~r_rvalid | w_pop) & ~flush & ~reset;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wrptr[DEPTH-1:0]),
        .i_wdata (wdata),
        .i_re    (w_prefetch),
        .i_raddr (r_rdptr[DEPTH-1:0]),
        .o_rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_count    <= '0;
            r_rvalid   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wrptr  <= '0;
            r_rdptr  <= '0;
            r_count  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wrptr <= r_wrptr + 1'b1;
            end
            if (w_prefetch) begin
                r_rdptr  <= r_rdptr + 1'b1;
                r_rvalid <= 1'b1;
            end else if (w_pop) begin
                r_rvalid <= 1'b0;
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rvalid       = r_rvalid;
    assign count        = r_count;
    assign not_full     = ~w_full;
    assign almost_full  = (int'(r_count) >= AFULL_LEVEL);
    assign almost_empty = (int'(r_count) <= AEMPTY_LEVEL);
    assign overflow     = r_overflow;

endmodule
